// File: rtl/param_mem_arbiter.sv
// param_mem_arbiter: shares one memory port between instruction-fetch and data requesters.
//
// Grants at most one request per cycle and forwards it combinationally to memory. The source
// of every accepted request is pushed into a tag FIFO. In-order memory responses are routed
// back to the requester at the FIFO head with zero latency.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imemreq_* / dmemreq_*      requester request ports (msg/val in, rdy out)
//   imemresp_* / dmemresp_*    requester response ports (msg/val out)
//   memreq_* / memresp_*       shared memory port
//   outstanding                accepted requests still awaiting a response
//   err_resp                   sticky: a response arrived with nothing in flight
//
// Build option: define PARAM_MEMARB_RR_EN to break both-valid ties round-robin
// instead of with fixed data-port priority.

module param_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned REQ_SZ          = 67,
  parameter int unsigned RESP_SZ         = 35
) (
  input  logic                              clk,
  input  logic                              reset,

  input  logic [REQ_SZ-1:0]                 imemreq_msg,
  input  logic                              imemreq_val,
  output logic                              imemreq_rdy,
  output logic [RESP_SZ-1:0]                imemresp_msg,
  output logic                              imemresp_val,

  input  logic [REQ_SZ-1:0]                 dmemreq_msg,
  input  logic                              dmemreq_val,
  output logic                              dmemreq_rdy,
  output logic [RESP_SZ-1:0]                dmemresp_msg,
  output logic                              dmemresp_val,

  output logic [REQ_SZ-1:0]                 memreq_msg,
  output logic                              memreq_val,
  input  logic                              memreq_rdy,
  input  logic [RESP_SZ-1:0]                memresp_msg,
  input  logic                              memresp_val,

  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_resp
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {
    SrcImem = 1'b0,
    SrcDmem = 1'b1
  } src_e;

  typedef enum logic {
    StOpen,
    StLocked
  } lock_st_e;

  lock_st_e          state_q, state_d;
  src_e              lock_src_q, lock_src_d;

  src_e              tag_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;

  logic              full, empty;
  logic              gnt_any, gnt_ok, gnt_req_val;
  src_e              gnt_src, tie_src, head_src;
  logic              accept, pop;

  // ---------------------------------------------------------------------------
  // Tie-break source
  // ---------------------------------------------------------------------------
`ifdef PARAM_MEMARB_RR_EN
  src_e rr_last_q, rr_last_d;

  assign tie_src = (rr_last_q == SrcImem) ? SrcDmem : SrcImem;

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) begin
      rr_last_d = gnt_src;
    end
  end

  // Resets to imem so the data port wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= SrcImem;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  assign tie_src = SrcDmem;
`endif

  // ---------------------------------------------------------------------------
  // Grant and request path
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CntW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  always_comb begin
    gnt_src = SrcImem;
    if (state_q == StLocked) begin
      gnt_src = lock_src_q;
    end else if (imemreq_val && dmemreq_val) begin
      gnt_src = tie_src;
    end else if (dmemreq_val) begin
      gnt_src = SrcDmem;
    end
  end

  // A full FIFO blocks all grants; a pop in the same cycle does not help.
  assign gnt_any     = (state_q == StLocked) | imemreq_val | dmemreq_val;
  assign gnt_ok      = gnt_any & ~full;
  assign gnt_req_val = (gnt_src == SrcDmem) ? dmemreq_val : imemreq_val;

  assign memreq_val  = gnt_ok & gnt_req_val;
  assign memreq_msg  = !gnt_ok ? '0 : ((gnt_src == SrcDmem) ? dmemreq_msg : imemreq_msg);

  assign imemreq_rdy = gnt_ok & (gnt_src == SrcImem) & memreq_rdy;
  assign dmemreq_rdy = gnt_ok & (gnt_src == SrcDmem) & memreq_rdy;

  assign accept      = memreq_val & memreq_rdy;

  // ---------------------------------------------------------------------------
  // Response path: route to FIFO head, drop and flag when nothing is in flight
  // ---------------------------------------------------------------------------
  assign head_src     = tag_q[rd_ptr_q];
  assign pop          = memresp_val & ~empty;

  assign imemresp_val = pop & (head_src == SrcImem);
  assign dmemresp_val = pop & (head_src == SrcDmem);
  assign imemresp_msg = imemresp_val ? memresp_msg : '0;
  assign dmemresp_msg = dmemresp_val ? memresp_msg : '0;

  assign outstanding  = count_q;
  assign err_resp     = err_q;

  // ---------------------------------------------------------------------------
  // Lock FSM: holds the stalled source so memreq_msg stays stable until accepted
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    if (accept) begin
      state_d = StOpen;
    end else if (memreq_val && !memreq_rdy) begin
      state_d    = StLocked;
      lock_src_d = gnt_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StOpen;
      lock_src_q <= SrcImem;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (memresp_val && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      tag_q[wr_ptr_q] <= gnt_src;
    end
  end

endmodule
